// File: rtl/ssd_scan_drv_pkg.sv
// Shared constants for the seven-segment scan path: BCD width, the
// active-low segment codes {a,b,c,d,e,f,g,dp} and the digit-select helper.
package ssd_scan_drv_pkg;

    localparam int BCD_BIT_WIDTH = 4;

    // Segment codes, active-low, bit order {a,b,c,d,e,f,g,dp}; dp off (1).
    localparam logic [7:0] SS_0     = 8'b0000_0011;
    localparam logic [7:0] SS_1     = 8'b1001_1111;
    localparam logic [7:0] SS_2     = 8'b0010_0101;
    localparam logic [7:0] SS_3     = 8'b0000_1101;
    localparam logic [7:0] SS_4     = 8'b1001_1001;
    localparam logic [7:0] SS_5     = 8'b0100_1001;
    localparam logic [7:0] SS_6     = 8'b0100_0001;
    localparam logic [7:0] SS_7     = 8'b0001_1111;
    localparam logic [7:0] SS_8     = 8'b0000_0001;
    localparam logic [7:0] SS_9     = 8'b0000_1001;
    localparam logic [7:0] SS_DASH  = 8'b1111_1101;
    localparam logic [7:0] SS_BLANK = 8'b1111_1111;

    // Active-low one-hot digit enable: idx 0 (leftmost) -> 0111, idx 3 -> 1110.
    function automatic logic [3:0] digit_sel(input logic [1:0] idx);
        return ~(4'b1000 >> idx);
    endfunction

endpackage

// File: rtl/ssd_scan_drv_if.sv
// Bundle between display_ctl (master) and the scan driver (slave).
// Plain level signals, no handshake: the master holds the digits and
// control masks steady, the slave samples them live on each scan tick
// and drives the registered digit enables and segment pins back.
interface ssd_scan_drv_if;
    import ssd_scan_drv_pkg::*;

    logic [BCD_BIT_WIDTH-1:0] in0;
    logic [BCD_BIT_WIDTH-1:0] in1;
    logic [BCD_BIT_WIDTH-1:0] in2;
    logic [BCD_BIT_WIDTH-1:0] in3;
    logic                     lz_blank;
    logic [3:0]               blink_en;
    logic [3:0]               dp_en;
    logic [3:0]               ssd_ctl;
    logic [7:0]               display;

    modport master (
        output in0, in1, in2, in3, lz_blank, blink_en, dp_en,
        input  ssd_ctl, display
    );

    modport slave (
        input  in0, in1, in2, in3, lz_blank, blink_en, dp_en,
        output ssd_ctl, display
    );

endinterface

// File: rtl/ssd_scan_drv_bcd2ssd.sv
// Combinational BCD to seven-segment decoder (active-low, dp left off).
// Non-decimal codes 10..15 show a dash so bad data is visible on the panel.
module bcd2ssd
    import ssd_scan_drv_pkg::*;
(
    input  logic [BCD_BIT_WIDTH-1:0] bcd,
    output logic [7:0]               seg
);

    // Table lookup of the segment pattern for one digit.
    always_comb begin
        seg = SS_DASH;
        case (bcd)
            4'd0:    seg = SS_0;
            4'd1:    seg = SS_1;
            4'd2:    seg = SS_2;
            4'd3:    seg = SS_3;
            4'd4:    seg = SS_4;
            4'd5:    seg = SS_5;
            4'd6:    seg = SS_6;
            4'd7:    seg = SS_7;
            4'd8:    seg = SS_8;
            4'd9:    seg = SS_9;
            default: seg = SS_DASH;
        endcase
    end

endmodule

// File: rtl/ssd_scan_drv.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A free-running prescaler produces scan_tick; on each tick the digit at
// idx is decoded, blanked/dotted as needed, and latched into the pin
// registers, then idx advances. A second counter on scan_tick sets the
// blink phase.
module ssd_scan_drv
    import ssd_scan_drv_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 16,
    parameter int BLINK_DIV_BITS = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    ssd_scan_drv_if.slave bus
);

    logic [SCAN_DIV_BITS-1:0]  prescaler;
    logic [BLINK_DIV_BITS-1:0] blink_cnt;
    logic                      blink_on;
    logic [1:0]                idx;
    logic                      scan_tick;

    logic [BCD_BIT_WIDTH-1:0]  cur_bcd;
    logic [7:0]                cur_seg;
    logic [3:0]                lead_zero;
    logic                      blanked;
    logic [7:0]                pattern;

    assign scan_tick = &prescaler;

    // Prescaler free-runs and wraps from all-ones to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prescaler <= '0;
        else        prescaler <= prescaler + 1'b1;
    end

    // Digit index advances once per scan tick, wrapping 3 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         idx <= 2'd0;
        else if (scan_tick) idx <= idx + 2'd1;
    end

    // Blink phase flips each time the blink counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (scan_tick) begin
            blink_cnt <= blink_cnt + 1'b1;
            if (&blink_cnt) blink_on <= ~blink_on;
        end
    end

    // Select the live digit under scan and the leading-zero run ending at each digit.
    always_comb begin
        cur_bcd = bus.in0;
        case (idx)
            2'd0:    cur_bcd = bus.in0;
            2'd1:    cur_bcd = bus.in1;
            2'd2:    cur_bcd = bus.in2;
            default: cur_bcd = bus.in3;
        endcase
        lead_zero    = 4'b0000;
        lead_zero[0] = (bus.in0 == '0);
        lead_zero[1] = lead_zero[0] && (bus.in1 == '0);
        lead_zero[2] = lead_zero[1] && (bus.in2 == '0);
        lead_zero[3] = lead_zero[2] && (bus.in3 == '0);
    end

    bcd2ssd u_bcd2ssd (
        .bcd (cur_bcd),
        .seg (cur_seg)
    );

    // Blanking wins over the decoded digit; the rightmost digit is never
    // zero-blanked so an all-zero value still shows a single 0.
    always_comb begin
        blanked = (!blink_on && bus.blink_en[idx])
               || (bus.lz_blank && (idx != 2'd3) && lead_zero[idx]);
        pattern = cur_seg;
        if (blanked)               pattern = SS_BLANK;
        else if (bus.dp_en[idx])   pattern[0] = 1'b0;
    end

    // Pin registers: dark at reset, loaded with the current digit on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ssd_ctl <= 4'b1111;
            bus.display <= SS_BLANK;
        end else if (scan_tick) begin
            bus.ssd_ctl <= digit_sel(idx);
            bus.display <= pattern;
        end
    end

endmodule
